// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port SRAM between the MEM stage (A)
// and the loader/debug port (B), with a bounded-starvation priority scheme.
module dmem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_chipSel,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_dat
);

    typedef enum logic {
        IDLE,
        RD_DATA
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state;
    logic [3:0]        streak;
    logic              rd_is_b;
    logic [ADDR_W-1:0] addr_q;

    logic              b_forced;
    logic              win_a;
    logic              win_b;
    logic              win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              drive;

    // B overrides A only once A has won LIMIT times in a row while B waited
    assign b_forced  = b_req && (streak == LIMIT);
    assign win_a     = (state == IDLE) && a_req && !b_forced;
    assign win_b     = (state == IDLE) && b_req && !win_a;
    assign win       = win_a || win_b;
    assign win_we    = win_b ? b_we : a_we;
    assign win_addr  = win_b ? b_addr : a_addr;
    assign win_wdata = win_b ? b_wdata : a_wdata;

    assign a_gnt       = rst_n && win_a;
    assign b_gnt       = rst_n && win_b;
    assign mem_chipSel = rst_n && (win || state == RD_DATA);
    assign drive       = rst_n && win && win_we;
    assign mem_write   = drive;
    assign mem_addr    = (rst_n && win) ? win_addr : addr_q;
    assign mem_dat     = drive ? win_wdata : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            streak   <= '0;
            rd_is_b  <= 1'b0;
            addr_q   <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (win) begin
                        addr_q  <= win_addr;
                        rd_is_b <= win_b;
                        if (!win_we) state <= RD_DATA;
                        if (win_b || !b_req) streak <= '0;
                        else if (streak != LIMIT) streak <= streak + 4'd1;
                    end
                end
                RD_DATA: begin
                    state <= IDLE;
                    if (rd_is_b) begin
                        b_rdata  <= mem_dat;
                        b_rvalid <= 1'b1;
                    end else begin
                        a_rdata  <= mem_dat;
                        a_rvalid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: SRAM model on the shared bus, a transaction-level
// reference model checked every cycle, directed scenarios and random traffic.
module tb_dmem_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [7:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_chipSel, mem_write;
    logic [7:0]  mem_addr;
    wire  [31:0] mem_dat;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_chipSel(mem_chipSel), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_dat(mem_dat)
    );

    // Registered-output SRAM: drives the bus whenever selected for reading
    logic [31:0] sram [256];
    logic [31:0] sram_q;
    assign mem_dat = (mem_chipSel && !mem_write) ? sram_q : 32'bz;
    always @(posedge clk) begin
        if (mem_chipSel) begin
            if (mem_write) sram[mem_addr] <= mem_dat;
            else sram_q <= sram[mem_addr];
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    int          cyc = 0;
    int          rd_cyc = -10;
    bit          pend = 0;
    bit          pend_b = 0;
    logic [31:0] pend_d = '0;
    int          a_streak = 0;
    logic [7:0]  last_addr = '0;
    logic [31:0] ea_rd = '0;
    logic [31:0] eb_rd = '0;
    logic [31:0] mmem [256];

    bit sa_gnt, sb_gnt, sa_rv, sb_rv;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_and_check();
        bit wa, wb, in_rd, ev_a, ev_b, we;
        logic [7:0] ad;
        logic [31:0] wd;
        wa = 0; wb = 0; in_rd = 0; ev_a = 0; ev_b = 0;
        if (!rst_n) begin
            pend = 0; a_streak = 0; last_addr = '0;
            ea_rd = '0; eb_rd = '0;
        end else begin
            if (pend && cyc == rd_cyc + 2) begin
                if (pend_b) begin ev_b = 1; eb_rd = pend_d; end
                else begin ev_a = 1; ea_rd = pend_d; end
                pend = 0;
            end
            in_rd = pend && (cyc == rd_cyc + 1);
            if (!in_rd) begin
                wa = a_req && !(b_req && a_streak >= LIM);
                wb = b_req && !wa;
            end
        end
        we = wb ? b_we : a_we;
        ad = wb ? b_addr : a_addr;
        wd = wb ? b_wdata : a_wdata;
        check("a_gnt", a_gnt, wa);
        check("b_gnt", b_gnt, wb);
        check("mem_chipSel", mem_chipSel, wa || wb || in_rd);
        check("mem_write", mem_write, (wa || wb) && we);
        check("mem_addr", mem_addr, (wa || wb) ? ad : last_addr);
        if ((wa || wb) && we) check("mem_dat", mem_dat, wd);
        check("a_rvalid", a_rvalid, ev_a);
        check("b_rvalid", b_rvalid, ev_b);
        check("a_rdata", a_rdata, ea_rd);
        check("b_rdata", b_rdata, eb_rd);
        if (wa || wb) begin
            if (we) mmem[ad] = wd;
            else begin
                pend = 1; rd_cyc = cyc; pend_b = wb; pend_d = mmem[ad];
            end
            last_addr = ad;
            if (wb || !b_req) a_streak = 0;
            else if (a_streak < LIM) a_streak++;
        end
        cyc++;
    endtask

    // Called just after a falling edge with inputs set; returns at the next one
    task automatic tick();
        #1;
        model_and_check();
        sa_gnt = a_gnt; sb_gnt = b_gnt;
        sa_rv = a_rvalid; sb_rv = b_rvalid;
        @(negedge clk);
        if (sa_gnt) a_req = 0;
        if (sb_gnt) b_req = 0;
    endtask

    task automatic set_a(input bit we, input logic [7:0] ad,
                         input logic [31:0] wd);
        a_req = 1; a_we = we; a_addr = ad; a_wdata = wd;
    endtask

    task automatic set_b(input bit we, input logic [7:0] ad,
                         input logic [31:0] wd);
        b_req = 1; b_we = we; b_addr = ad; b_wdata = wd;
    endtask

    // Issue an A read; returns ticks from grant to rvalid (6 = timed out)
    task automatic a_read(input logic [7:0] ad, output int lat);
        int w;
        set_a(0, ad, '0);
        w = 0;
        tick();
        while (!sa_gnt && w < 6) begin tick(); w++; end
        lat = 0;
        while (!sa_rv && lat < 6) begin tick(); lat++; end
    endtask

    logic [31:0] vals [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, k, ga, gb, rvb, both, ngnt, bpos, a_after, rvseen;
        rst_n = 0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        @(negedge clk);
        tick(); tick();
        rst_n = 1;
        repeat (3) tick();

        // A write then read of 0x10
        set_a(1, 8'h10, 32'hDEADBEEF);
        #1;
        check("wr_gnt_lit", a_gnt, 1);
        check("wr_dat_lit", mem_dat, 32'hDEADBEEF);
        tick();
        a_read(8'h10, lat);
        check("rd_latency_lit", lat, 2);
        check("rd_data_lit", a_rdata, 32'hDEADBEEF);

        // Preload 0x01 via A and 0x02 via B, then simultaneous reads
        set_a(1, 8'h01, 32'h11111111);
        tick();
        set_b(1, 8'h02, 32'h22222222);
        tick();
        set_a(0, 8'h01, '0);
        set_b(0, 8'h02, '0);
        ga = -1; gb = -1; rvb = -1; both = 0;
        for (k = 0; k < 8; k++) begin
            tick();
            if (sa_gnt && ga < 0) ga = k;
            if (sb_gnt && gb < 0) gb = k;
            if (sb_rv && rvb < 0) rvb = k;
            if (sa_rv && sb_rv) both++;
        end
        check("sim_a_gnt_cycle", ga, 0);
        check("sim_b_gnt_cycle", gb, 2);
        check("sim_b_rvalid_cycle", rvb, 4);
        check("sim_rvalid_overlap", both, 0);
        check("sim_a_rdata_lit", a_rdata, 32'h11111111);
        check("sim_b_rdata_lit", b_rdata, 32'h22222222);

        // Back-to-back writes 0x00..0x0F, then readback
        ngnt = 0;
        for (int i = 0; i < 16; i++) begin
            vals[i] = $urandom;
            set_a(1, 8'(i), vals[i]);
            tick();
            if (sa_gnt && i < 8) ngnt++;
        end
        check("b2b_gnt_count", ngnt, 8);
        for (int i = 0; i < 16; i++) begin
            a_read(8'(i), lat);
            check("readback", a_rdata, vals[i]);
        end

        // Starvation guard: A streams writes, B holds a write to 0x80
        bpos = -1; a_after = 0;
        set_b(1, 8'h80, 32'hB0B0B0B0);
        for (int opp = 1; opp <= 7; opp++) begin
            if (!a_req) set_a(1, 8'(8'h40 + opp), $urandom);
            tick();
            if (sb_gnt) bpos = opp;
            if (bpos > 0 && opp == bpos + 1) a_after = sa_gnt;
        end
        a_req = 0;
        check("starve_b_pos", bpos, 5);
        check("starve_a_next", a_after, 1);

        // Reset asserted during RD_DATA abandons the read
        set_a(0, 8'h10, '0);
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        rvseen = 0;
        repeat (3) begin tick(); rvseen += int'(sa_rv); end
        check("rst_rd_no_rvalid", rvseen, 0);
        check("rst_rd_rdata_lit", a_rdata, 32'h0);
        a_read(8'h10, lat);
        check("rst_reissue_lat", lat, 2);
        check("rst_reissue_data", a_rdata, 32'hDEADBEEF);

        // Random traffic on the initialised range
        for (int n = 0; n < 800; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if (!a_req && $urandom_range(0, 2) != 0)
                set_a($urandom_range(0, 1), 8'($urandom_range(0, 15)),
                      $urandom);
            if (!b_req && $urandom_range(0, 2) == 0)
                set_b($urandom_range(0, 1), 8'($urandom_range(0, 15)),
                      $urandom);
            tick();
        end
        rst_n = 1;
        a_req = 0; b_req = 0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
